// File: rtl/v_lane_writeback.sv
// v_lane_writeback: captures lane result groups on done and writes 1/2/4 vector registers
// through a valid/ready port with tail-undisturbed byte enables.
module v_lane_writeback #(
  parameter int VLEN      = 128,
  parameter int NREG_ADDR = 5,
  parameter int VL_W      = 7
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 done,
  input  logic                 is_mul,
  input  logic [2:0]           lmul,
  input  logic [2:0]           vsew,
  input  logic [VL_W-1:0]      vl,
  input  logic [NREG_ADDR-1:0] vd,
  input  logic [VLEN-1:0]      result_valu_1,
  input  logic [VLEN-1:0]      result_valu_2,
  input  logic [VLEN-1:0]      result_valu_3,
  input  logic [VLEN-1:0]      result_valu_4,
  input  logic [VLEN-1:0]      result_vmul_1,
  input  logic [VLEN-1:0]      result_vmul_2,
  input  logic [VLEN-1:0]      result_vmul_3,
  input  logic [VLEN-1:0]      result_vmul_4,
  output logic                 vrf_we,
  output logic [NREG_ADDR-1:0] vrf_addr,
  output logic [VLEN-1:0]      vrf_wdata,
  output logic [15:0]          vrf_be,
  input  logic                 vrf_ready,
  output logic                 busy,
  output logic                 wb_done,
  output logic                 overrun
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t                state_q, state_d;
  logic [1:0]            k_q, k_d, last_q, last_d, sew_q, sew_d;
  logic [VL_W-1:0]       vl_q, vl_d;
  logic [NREG_ADDR-1:0]  vd_q, vd_d;
  logic [VLEN-1:0]       grp_q [4];
  logic [VLEN-1:0]       grp_d [4];
  logic                  overrun_q, overrun_d;
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    last_d    = last_q;
    sew_d     = sew_q;
    vl_d      = vl_q;
    vd_d      = vd_q;
    grp_d     = grp_q;
    overrun_d = overrun_q | (done && state_q == WRITE);
    if (done && state_q != WRITE) begin
      if (is_mul) grp_d = '{result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4};
      else        grp_d = '{result_valu_1, result_valu_2, result_valu_3, result_valu_4};
      last_d  = lmul == 3'b001 ? 2'd1 : lmul == 3'b010 ? 2'd3 : 2'd0;
      sew_d   = vsew > 3'd2 ? 2'd2 : vsew[1:0];
      vl_d    = vl;
      vd_d    = vd;
      k_d     = '0;
      state_d = vl == '0 ? DONE : WRITE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == WRITE && vrf_ready) begin
      k_d     = k_q + 2'd1;
      state_d = k_q == last_q ? DONE : WRITE;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      last_q    <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vd_q      <= '0;
      grp_q     <= '{default: '0};
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      last_q    <= last_d;
      sew_q     <= sew_d;
      vl_q      <= vl_d;
      vd_q      <= vd_d;
      grp_q     <= grp_d;
      overrun_q <= overrun_d;
    end
  end
  assign vrf_we    = state_q == WRITE;
  assign busy      = state_q != IDLE;
  assign wb_done   = state_q == DONE;
  assign overrun   = overrun_q;
  assign vrf_addr  = vrf_we ? vd_q + NREG_ADDR'(k_q) : '0;
  assign vrf_wdata = vrf_we ? grp_q[k_q] : '0;
  // Byte b of register k holds element (16k+b)>>sew; bytes past vl stay untouched.
  always_comb begin
    vrf_be = '0;
    for (int b = 0; b < 16; b++)
      vrf_be[b] = vrf_we && ((VL_W'({k_q, 4'(b)}) >> sew_q) < vl_q);
  end
endmodule

// File: tb/tb_v_lane_writeback.sv
// tb_v_lane_writeback: randomized and directed stimulus checked against a queue-based
// model of the expected register writes and completion timing.
module tb_v_lane_writeback;
  logic         clk = 0, nrst = 0, done = 0, is_mul = 0, vrf_ready = 0;
  logic [2:0]   lmul = 0, vsew = 0;
  logic [6:0]   vl = 0;
  logic [4:0]   vd = 0;
  logic [127:0] valu [4];
  logic [127:0] vmul [4];
  logic         vrf_we, busy, wb_done, overrun;
  logic [4:0]   vrf_addr;
  logic [127:0] vrf_wdata;
  logic [15:0]  vrf_be;
  int checks = 0, errors = 0, cyc = 0, id_n = 0;
  bit exp_ovr = 0;

  typedef struct {logic [4:0] addr; logic [127:0] data; logic [15:0] be; int id;} wr_t;
  typedef struct {bit mul; logic [2:0] lmul; logic [2:0] sew; int vl; int vd;} ins_t;
  wr_t exp_q[$];
  int  wb_q[$];
  int  lat_q[$];

  always #5 clk = ~clk;

  v_lane_writeback dut (
    .clk(clk), .nrst(nrst), .done(done), .is_mul(is_mul), .lmul(lmul), .vsew(vsew),
    .vl(vl), .vd(vd),
    .result_valu_1(valu[0]), .result_valu_2(valu[1]), .result_valu_3(valu[2]), .result_valu_4(valu[3]),
    .result_vmul_1(vmul[0]), .result_vmul_2(vmul[1]), .result_vmul_3(vmul[2]), .result_vmul_4(vmul[3]),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_wdata(vrf_wdata), .vrf_be(vrf_be),
    .vrf_ready(vrf_ready), .busy(busy), .wb_done(wb_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      valu[i] = rnd128();
      vmul[i] = rnd128();
    end
  endtask

  function automatic ins_t rnd_ins();
    ins_t t;
    t.mul  = 1'($urandom_range(1));
    t.lmul = 3'($urandom_range(7));
    t.sew  = 3'($urandom_range(7));
    t.vl   = int'($urandom_range(64));
    t.vd   = int'($urandom_range(31));
    return t;
  endfunction

  // Drives done for one cycle; when the instruction will be accepted, records the writes
  // it must produce: element count * element bytes gives the number of live bytes.
  task automatic issue(input ins_t t, input bit accepted);
    int n, bytes;
    scramble();
    done = 1; is_mul = t.mul; lmul = t.lmul; vsew = t.sew; vl = 7'(t.vl); vd = 5'(t.vd);
    if (!accepted) return;
    n = t.lmul == 3'b001 ? 2 : t.lmul == 3'b010 ? 4 : 1;
    if (t.vl == 0) n = 0;
    bytes = t.vl * (1 << (t.sew > 2 ? 2 : t.sew));
    for (int k = 0; k < n; k++) begin
      wr_t w;
      w.addr = 5'((t.vd + k) % 32);
      w.data = t.mul ? vmul[k] : valu[k];
      for (int b = 0; b < 16; b++) w.be[b] = (16 * k + b) < bytes;
      w.id = id_n;
      exp_q.push_back(w);
    end
    wb_q.push_back(id_n);
    lat_q.push_back(cyc + n + 2);
    id_n++;
  endtask

  task automatic run(input ins_t a, input int rdy_pct, input int stall, input bit inject,
                     input bit chain, input ins_t b);
    bit fire = 0, fired = 0;
    int it = 0;
    while ((it == 0 || wb_q.size() != 0 || fire) && it < 300) begin
      @(posedge clk); #1;
      it++;
      done = 0;
      scramble();
      vrf_ready = (it <= stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (it == 1) issue(a, 1);
      else if (fire) begin issue(b, 1); fire = 0; fired = 1; end
      else if (inject && it == 2) begin issue(b, 0); exp_ovr = 1; end
      @(negedge clk);
      cyc++;
      if (vrf_we) begin
        chk("busy_wr", busy, 1);
        if (exp_q.size() == 0) chk("stray_we", vrf_we, 0);
        else begin
          chk("addr", vrf_addr, exp_q[0].addr);
          chk("data", vrf_wdata, exp_q[0].data);
          chk("be", vrf_be, exp_q[0].be);
          if (vrf_ready) begin
            void'(exp_q.pop_front());
            if (chain && !fired && exp_q.size() == 0) fire = 1;
          end
        end
      end
      if (wb_done) begin
        chk("busy_done", busy, 1);
        chk("we_at_done", vrf_we, 0);
        if (wb_q.size() == 0) chk("stray_wb", wb_done, 0);
        else begin
          int id, lat, rem;
          id = wb_q.pop_front();
          lat = lat_q.pop_front();
          rem = 0;
          foreach (exp_q[i]) if (exp_q[i].id == id) rem++;
          chk("wb_remaining", rem, 0);
          if (rdy_pct == 100 && stall == 0) chk("wb_latency", cyc, lat);
        end
      end
    end
    if (wb_q.size() != 0) chk("timeout", wb_q.size(), 0);
    exp_q.delete(); wb_q.delete(); lat_q.delete();
    @(posedge clk); #1;
    vrf_ready = 1;
    @(negedge clk);
    cyc++;
    chk("idle_we", vrf_we, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wb", wb_done, 0);
    chk("overrun", overrun, exp_ovr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    ins_t z, r1, r2;
    z = '{1'b0, 3'b000, 3'd0, 1, 0};
    scramble();
    #1;
    chk("rst_we", vrf_we, 0); chk("rst_addr", vrf_addr, 0); chk("rst_data", vrf_wdata, 0);
    chk("rst_be", vrf_be, 0); chk("rst_busy", busy, 0); chk("rst_wb", wb_done, 0);
    chk("rst_ovr", overrun, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1;
    run('{1'b0, 3'b000, 3'd2, 4, 8}, 100, 0, 0, 0, z);
    run('{1'b1, 3'b010, 3'd0, 40, 4}, 100, 0, 0, 0, z);
    run('{1'b0, 3'b001, 3'd1, 10, 2}, 100, 4, 0, 0, z);
    run('{1'b0, 3'b000, 3'd0, 0, 9}, 100, 0, 0, 0, z);
    run('{1'b1, 3'b001, 3'd2, 7, 31}, 100, 0, 0, 0, z);
    run('{1'b0, 3'b011, 3'd3, 3, 17}, 100, 0, 0, 0, z);
    run('{1'b0, 3'b010, 3'd2, 16, 0}, 100, 0, 1, 0, '{1'b1, 3'b001, 3'd0, 64, 20});
    run('{1'b1, 3'b010, 3'd2, 13, 29}, 100, 0, 0, 1, '{1'b0, 3'b001, 3'd1, 20, 31});
    for (int i = 0; i < 40; i++) begin
      r1 = rnd_ins();
      r2 = rnd_ins();
      run(r1, (i % 2) ? 100 : 60, 0, 0, 1'($urandom_range(1)), r2);
    end
    // Abandon a 4-register instruction mid-write.
    @(posedge clk); #1;
    vrf_ready = 0;
    issue('{1'b0, 3'b010, 3'd0, 64, 12}, 1);
    @(posedge clk); #1;
    done = 0;
    @(posedge clk); #1;
    vrf_ready = 1;
    @(negedge clk);
    chk("pre_rst_we", vrf_we, 1);
    #2 nrst = 0;
    #1;
    chk("mid_rst_we", vrf_we, 0); chk("mid_rst_addr", vrf_addr, 0); chk("mid_rst_data", vrf_wdata, 0);
    chk("mid_rst_be", vrf_be, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_ovr", overrun, 0);
    exp_q.delete(); wb_q.delete(); lat_q.delete();
    exp_ovr = 0;
    repeat (2) @(negedge clk) chk("rst_no_wb", wb_done, 0);
    @(posedge clk); #1 nrst = 1;
    run('{1'b1, 3'b010, 3'd1, 25, 6}, 100, 0, 0, 0, z);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v_lane_writeback.md
Name: v_lane_writeback

Overview:
- Sits directly downstream of the vector lane array and captures the four 128-bit ALU and multiplier result groups when the lanes pulse `done`.
- Selects ALU or MUL results and writes 1, 2 or 4 vector registers (per LMUL) sequentially into the vector register file.
- Applies a per-byte enable derived from vl and SEW, giving tail-undisturbed behaviour.
- Decouples lane completion from register-file port availability with a valid/ready write handshake.

Parameters:
- VLEN, 128, bits per vector register and per result group.
- NREG_ADDR, 5, vector register address width (32 registers).
- VL_W, 7, width of vl (max 64 elements at SEW=8, LMUL=4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- done  input  1  single-cycle pulse from lanes; result groups valid this cycle.
- is_mul  input  1  1 selects result_vmul_*, 0 selects result_valu_*; sampled with done.
- lmul  input  3  3'b001 → 2 regs, 3'b010 → 4 regs, any other → 1 reg; sampled with done.
- vsew  input  3  0=8b, 1=16b, 2=32b; values >2 treated as 2; sampled with done.
- vl  input  VL_W  active element count; sampled with done.
- vd  input  NREG_ADDR  destination base register; sampled with done.
- result_valu_1..4  input  VLEN each  ALU result groups 1..4.
- result_vmul_1..4  input  VLEN each  MUL result groups 1..4.
- vrf_we  output  1  write request valid.
- vrf_addr  output  NREG_ADDR  register being written.
- vrf_wdata  output  VLEN  write data.
- vrf_be  output  16  byte enables; bit b covers wdata[8b+7:8b].
- vrf_ready  input  1  register file accepts a write when vrf_we && vrf_ready.
- busy  output  1  capture buffer occupied (state WRITE or DONE).
- wb_done  output  1  one-cycle pulse after the last write of an instruction is accepted.
- overrun  output  1  sticky; set when done arrives while in WRITE; cleared only by reset.

Behaviour:
- Reset (nrst=0, async): state IDLE; vrf_we=0, vrf_addr=0, vrf_wdata=0, vrf_be=0, busy=0, wb_done=0, overrun=0; capture buffer and counters cleared. Reset mid-write abandons remaining writes with no wb_done.
- FSM states: IDLE, WRITE, DONE.
- IDLE or DONE, done=1:
  - Capture the selected four groups, nregs, vsew, vl and vd; clear counter k=0.
  - If vl==0, go to DONE (no writes); otherwise go to WRITE.
- WRITE:
  - vrf_we=1 (registered), vrf_addr=(vd+k) mod 32 (5-bit wrap; misaligned vd is not trapped), vrf_wdata=group k+1.
  - vrf_be[b]=1 iff ((16k+b)>>vsew) < vl.
  - On handshake: k++. If k was nregs-1, go to DONE and drop vrf_we the next cycle. Without handshake, all outputs hold stable.
- DONE: wb_done=1 for exactly one cycle, then IDLE. A done in this cycle is accepted (back-to-back instructions).
- done in WRITE: ignored (buffer unchanged), overrun←1.
- done in IDLE with no write activity leaves overrun unchanged.
- Latency with vrf_ready tied to 1: done at cycle N → writes in cycles N+1..N+nregs, wb_done at N+nregs+1.
- Throughput: one register per cycle; vrf_ready low stalls indefinitely without data loss.
- busy=1 in WRITE and DONE.

Test Plan:
- lmul=0, is_mul=0, vsew=2, vl=4, vd=8, valu_1=0x…0004_0003_0002_0001, ready=1 → one write at N+1: addr 8, be=16'hFFFF, data=valu_1; wb_done at N+2.
- lmul=2, is_mul=1, vsew=0, vl=40, vd=4 → addrs 4,5,6,7 with data vmul_1..4; be = FFFF, FFFF, 00FF, 0000; wb_done at N+5.
- lmul=1, vsew=1, vl=10, vd=2, vrf_ready low for 3 cycles at the first write → addr 2 held stable for 3 cycles, then addr 3 with be=16'h000F; no data change while stalled.
- Second done during WRITE (lmul=2) → ignored, overrun=1, first instruction completes intact; done coincident with wb_done → accepted, new writes begin the next cycle.
- vl=0 → no vrf_we, wb_done one cycle after done. vd=31 with lmul=1 → addrs 31, 0.
- nrst asserted mid-write of a 4-register instruction → all outputs 0 immediately, no wb_done; a fresh done after release works normally.
